// File: rtl/alu_pkg.sv
// Shared opcode map, default width and stage-2 payload layout for the pipelined ALU.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [3:0] OP_ADD         = 4'd0;
   localparam logic [3:0] OP_SUB         = 4'd1;
   localparam logic [3:0] OP_SHL         = 4'd2;
   localparam logic [3:0] OP_SHR         = 4'd3;
   localparam logic [3:0] OP_ROL         = 4'd4;
   localparam logic [3:0] OP_ROR         = 4'd5;
   localparam logic [3:0] OP_AND         = 4'd6;
   localparam logic [3:0] OP_OR          = 4'd7;
   localparam logic [3:0] OP_NOT         = 4'd8;
   localparam logic [3:0] OP_NAND        = 4'd9;
   localparam logic [3:0] OP_XOR         = 4'd10;
   localparam logic [3:0] OP_XNOR        = 4'd11;
   localparam logic [3:0] OP_NOR         = 4'd12;
   localparam logic [3:0] OP_ILLEGAL_MIN = 4'd13;

   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] results;
      logic                     carry_out;
      logic                     illegal;
   } alu_result_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response handshake bundle between an ALU client (master) and alu_pipe (slave).
interface alu_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       sel;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] results;
   logic             carry_out;
   logic             illegal;
   logic [CNT_W-1:0] op_count;
   logic             illegal_seen;

   modport master (
      output in_valid, A, B, sel, carry_in, out_ready,
      input  in_ready, out_valid, results, carry_out, illegal, op_count, illegal_seen
   );

   modport slave (
      input  in_valid, A, B, sel, carry_in, out_ready,
      output in_ready, out_valid, results, carry_out, illegal, op_count, illegal_seen
   );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: operands and opcode in, stage-2 payload out.
module alu_core
   import alu_pkg::*;
(
   input  logic [DEFAULT_WIDTH-1:0] a,
   input  logic [DEFAULT_WIDTH-1:0] b,
   input  logic [3:0]               sel,
   input  logic                     carry_in,
   output alu_result_t              res
);
   localparam int W = DEFAULT_WIDTH;

   logic [2:0] n;
   logic [W:0] wide;

   assign n = b[2:0];

   always_comb begin
      res  = '0;
      wide = '0;
      case (sel)
         OP_ADD: begin
            wide          = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
            res.results   = wide[W-1:0];
            res.carry_out = wide[W];
         end
         OP_SUB: begin
            // The extra top bit of the difference is the borrow.
            wide          = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, carry_in};
            res.results   = wide[W-1:0];
            res.carry_out = wide[W];
         end
         OP_SHL: begin
            wide          = {1'b0, a} << n;
            res.results   = wide[W-1:0];
            res.carry_out = wide[W];
         end
         OP_SHR: begin
            wide          = {a, 1'b0} >> n;
            res.results   = wide[W:1];
            res.carry_out = wide[0];
         end
         OP_ROL:  res.results = (a << n) | (a >> (W - int'(n)));
         OP_ROR:  res.results = (a >> n) | (a << (W - int'(n)));
         OP_AND:  res.results = a & b;
         OP_OR:   res.results = a | b;
         OP_NOT:  res.results = ~a;
         OP_NAND: res.results = ~(a & b);
         OP_XOR:  res.results = a ^ b;
         OP_XNOR: res.results = ~(a ^ b);
         OP_NOR:  res.results = ~(a | b);
         default: res.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with a delivered-op counter and sticky illegal flag.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 16
)(
   input  logic     clk,
   input  logic     rst_n,
   alu_pipe_if.slave bus
);
   logic             s1_valid_reg;
   logic [WIDTH-1:0] s1_a_reg;
   logic [WIDTH-1:0] s1_b_reg;
   logic [3:0]       s1_sel_reg;
   logic             s1_cin_reg;
   logic             s2_valid_reg;
   alu_result_t      s2_res_reg;
   alu_result_t      core_res;
   logic [CNT_W-1:0] op_count_reg;
   logic             illegal_seen_reg;

   logic s1_advance;
   logic s2_advance;
   logic deliver;

   // No skid buffer: in_ready depends combinationally on out_ready.
   assign s2_advance = !s2_valid_reg || bus.out_ready;
   assign s1_advance = !s1_valid_reg || s2_advance;
   assign deliver    = s2_valid_reg && bus.out_ready;

   alu_core u_core (
      .a        (s1_a_reg),
      .b        (s1_b_reg),
      .sel      (s1_sel_reg),
      .carry_in (s1_cin_reg),
      .res      (core_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg     <= 1'b0;
         s1_a_reg         <= '0;
         s1_b_reg         <= '0;
         s1_sel_reg       <= '0;
         s1_cin_reg       <= 1'b0;
         s2_valid_reg     <= 1'b0;
         s2_res_reg       <= '0;
         op_count_reg     <= '0;
         illegal_seen_reg <= 1'b0;
      end else begin
         if (s1_advance) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
               s1_a_reg   <= bus.A;
               s1_b_reg   <= bus.B;
               s1_sel_reg <= bus.sel;
               s1_cin_reg <= bus.carry_in;
            end
         end
         if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               s2_res_reg <= core_res;
            end
         end
         if (deliver) begin
            op_count_reg <= op_count_reg + 1'b1;
            if (s2_res_reg.illegal) begin
               illegal_seen_reg <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready     = s1_advance;
   assign bus.out_valid    = s2_valid_reg;
   assign bus.results      = s2_res_reg.results;
   assign bus.carry_out    = s2_res_reg.carry_out;
   assign bus.illegal      = s2_res_reg.illegal;
   assign bus.op_count     = op_count_reg;
   assign bus.illegal_seen = illegal_seen_reg;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe: reset, opcode results, latency, backpressure, illegal flag, counter wrap.
module tb_alu_pipe;
   import alu_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   alu_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();

   alu_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total   = 0;
   int bad     = 0;
   int exp_ops = 0;

   // Issue one op into an empty pipeline; report out_valid one and two edges after acceptance.
   task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                           input logic cin, output logic [7:0] r, output logic c,
                           output logic il, output logic early, output logic late);
      bus.A = a; bus.B = b; bus.sel = s; bus.carry_in = cin;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      early = bus.out_valid;
      @(posedge clk); #1;
      late = bus.out_valid; r = bus.results; c = bus.carry_out; il = bus.illegal;
      exp_ops++;
      $display("op sel=%0d A=%h B=%h cin=%b -> results=%h carry=%b illegal=%b", s, a, b, cin, r, c, il);
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      bus.A = 8'h12; bus.B = 8'h34; bus.sel = OP_ADD; bus.carry_in = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      total++; if (bus.op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count: got %0d want 0", bus.op_count); end
      total++; if (bus.results !== 8'h00 || bus.carry_out !== 1'b0 || bus.illegal !== 1'b0 || bus.illegal_seen !== 1'b0) begin
         bad++; $display("FAIL reset_outputs: got res=%h c=%b il=%b seen=%b want all 0", bus.results, bus.carry_out, bus.illegal, bus.illegal_seen);
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_phantom: got out_valid=%b want 0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      logic [7:0] ea [6];
      logic [7:0] eb [6];
      int n_in = 0, n_out = 0, cyc = 0;
      logic saw_stall = 1'b0, prev_hold = 1'b0, acc, del;
      logic [7:0] prev_res = '0;
      for (int i = 0; i < 6; i++) begin
         ea[i] = 8'(i * 16 + 3);
         eb[i] = 8'(i + 1);
      end
      while (n_out < 6 && cyc < 40) begin
         bus.out_ready = (cyc >= 4);
         if (n_in < 6) begin
            bus.A = ea[n_in]; bus.B = eb[n_in]; bus.sel = OP_ADD; bus.carry_in = 1'b0; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         acc = bus.in_valid && bus.in_ready;
         del = bus.out_valid && bus.out_ready;
         if (!bus.in_ready) saw_stall = 1'b1;
         if (prev_hold) begin
            total++; if (bus.results !== prev_res) begin bad++; $display("FAIL bp_stable: got %h want %h", bus.results, prev_res); end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_res  = bus.results;
         if (del) begin
            total++;
            if (bus.results !== 8'(ea[n_out] + eb[n_out])) begin
               bad++; $display("FAIL bp_order[%0d]: got %h want %h", n_out, bus.results, 8'(ea[n_out] + eb[n_out]));
            end
            $display("bp deliver #%0d results=%h", n_out, bus.results);
            n_out++;
            exp_ops++;
         end
         @(posedge clk); #1;
         if (acc) n_in++;
         cyc++;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      total++; if (n_out != 6) begin bad++; $display("FAIL bp_timeout: delivered %0d want 6", n_out); end
      total++; if (cyc != 10) begin bad++; $display("FAIL bp_throughput: took %0d cycles want 10", cyc); end
      total++; if (!saw_stall) begin bad++; $display("FAIL bp_stall: in_ready never 0, want 0 while 2 ops held"); end
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_duplicate: got out_valid=%b want 0", bus.out_valid); end
      total++; if (bus.op_count !== 16'd6) begin bad++; $display("FAIL bp_op_count: got %0d want 6", bus.op_count); end
   endtask

   task automatic test_add_sub();
      logic [7:0] ta [4] = '{8'hFF, 8'h00, 8'h12, 8'h50};
      logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h34, 8'h20};
      logic [3:0] ts [4] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB};
      logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] er [4] = '{8'h00, 8'hFE, 8'h47, 8'h30};
      logic       ec [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] r; logic c, il, early, late;
      for (int i = 0; i < 4; i++) begin
         issue_op(ta[i], tb[i], ts[i], tc[i], r, c, il, early, late);
         total++; if (early !== 1'b0 || late !== 1'b1) begin bad++; $display("FAIL arith_latency[%0d]: got early=%b late=%b want 0/1", i, early, late); end
         total++; if (r !== er[i]) begin bad++; $display("FAIL arith_result[%0d]: got %h want %h", i, r, er[i]); end
         total++; if (c !== ec[i] || il !== 1'b0) begin bad++; $display("FAIL arith_carry[%0d]: got c=%b il=%b want c=%b il=0", i, c, il, ec[i]); end
      end
   endtask

   task automatic test_shift();
      logic [7:0] ta [9] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
      logic [7:0] tb [9] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h00, 8'hF9, 8'h01, 8'h00, 8'h00};
      logic [3:0] ts [9] = '{OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_SHL, OP_SHL, OP_SHR, OP_SHR, OP_ROL};
      logic [7:0] er [9] = '{8'h08, 8'h10, 8'h0C, 8'h30, 8'h81, 8'h02, 8'h40, 8'h81, 8'h81};
      logic       ec [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] r; logic c, il, early, late;
      for (int i = 0; i < 9; i++) begin
         issue_op(ta[i], tb[i], ts[i], 1'b1, r, c, il, early, late);
         total++; if (r !== er[i] || late !== 1'b1) begin bad++; $display("FAIL shift_result[%0d]: got %h valid=%b want %h", i, r, late, er[i]); end
         total++; if (c !== ec[i]) begin bad++; $display("FAIL shift_carry[%0d]: got %b want %b", i, c, ec[i]); end
      end
   endtask

   task automatic test_logic();
      logic [3:0] ts [7] = '{OP_AND, OP_OR, OP_NOT, OP_NAND, OP_XOR, OP_XNOR, OP_NOR};
      logic [7:0] er [7] = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'hCC, 8'h33, 8'h03};
      logic [7:0] r; logic c, il, early, late;
      for (int i = 0; i < 7; i++) begin
         issue_op(8'hF0, 8'h3C, ts[i], 1'b1, r, c, il, early, late);
         total++; if (r !== er[i] || c !== 1'b0 || il !== 1'b0 || late !== 1'b1) begin
            bad++; $display("FAIL logic[%0d]: got %h c=%b il=%b valid=%b want %h c=0 il=0", i, r, c, il, late, er[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [3:0] ts [3] = '{4'hE, 4'hD, 4'hF};
      logic [7:0] r; logic c, il, early, late;
      for (int i = 0; i < 3; i++) begin
         issue_op(8'h55, 8'hAA, ts[i], 1'b1, r, c, il, early, late);
         total++; if (r !== 8'h00 || c !== 1'b0 || il !== 1'b1 || late !== 1'b1) begin
            bad++; $display("FAIL illegal[%0d]: got %h c=%b il=%b valid=%b want 00 c=0 il=1", i, r, c, il, late);
         end
         @(posedge clk); #1;
         total++; if (bus.illegal_seen !== 1'b1) begin bad++; $display("FAIL illegal_seen_set[%0d]: got %b want 1", i, bus.illegal_seen); end
      end
      issue_op(8'h01, 8'h01, OP_ADD, 1'b0, r, c, il, early, late);
      total++; if (r !== 8'h02 || il !== 1'b0) begin bad++; $display("FAIL legal_after_illegal: got %h il=%b want 02 il=0", r, il); end
      @(posedge clk); #1;
      total++; if (bus.illegal_seen !== 1'b1) begin bad++; $display("FAIL illegal_seen_sticky: got %b want 1", bus.illegal_seen); end
      total++; if (bus.op_count !== 16'(exp_ops)) begin bad++; $display("FAIL op_count_running: got %0d want %0d", bus.op_count, exp_ops); end
   endtask

   task automatic test_reset_midflight();
      logic leaked = 1'b0;
      bus.out_ready = 1'b0;
      bus.A = 8'h10; bus.B = 8'h20; bus.sel = OP_ADD; bus.carry_in = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.A = 8'h30; bus.B = 8'h40;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midflight_setup: got out_valid=%b want 1", bus.out_valid); end
      rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL midflight_async: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      total++; if (bus.op_count !== 16'd0 || bus.illegal_seen !== 1'b0) begin
         bad++; $display("FAIL midflight_counters: got count=%0d seen=%b want 0/0", bus.op_count, bus.illegal_seen);
      end
      #3 rst_n = 1'b1;
      exp_ops = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) leaked = 1'b1;
      end
      total++; if (leaked || bus.op_count !== 16'd0) begin
         bad++; $display("FAIL midflight_discard: got leaked=%b count=%0d want 0/0", leaked, bus.op_count);
      end
   endtask

   task automatic test_wrap();
      int n = 65536 - exp_ops;
      int acc = 0, cyc = 0;
      logic [7:0] r; logic c, il, early, late;
      bus.A = 8'h01; bus.B = 8'h02; bus.sel = OP_ADD; bus.carry_in = 1'b0;
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      while (acc < n && cyc < 70000) begin
         if (bus.in_ready) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_ops = exp_ops + acc;
      $display("bulk stream of %0d ADD ops, op_count=%0d", acc, bus.op_count);
      total++; if (acc != n) begin bad++; $display("FAIL wrap_timeout: accepted %0d want %0d", acc, n); end
      total++; if (bus.op_count !== 16'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", bus.op_count); end
      issue_op(8'h01, 8'h02, OP_ADD, 1'b0, r, c, il, early, late);
      @(posedge clk); #1;
      total++; if (r !== 8'h03 || bus.op_count !== 16'd1) begin
         bad++; $display("FAIL wrap_continue: got res=%h count=%0d want 03/1", r, bus.op_count);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.A = '0; bus.B = '0; bus.sel = '0; bus.carry_in = 1'b0;
      test_reset();
      test_backpressure();
      test_add_sub();
      test_shift();
      test_logic();
      test_illegal();
      test_reset_midflight();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Synthesizable, 2-stage pipelined 8-bit ALU with a valid/ready handshake on both the input and output sides.
- Answers operation requests (A, B, sel, carry_in) with a result and a carry flag.
- Consumes the A/B/sel/carry stimulus that the team's existing ALU vector benches produce.
- Keeps a wrapping completed-operation counter and a sticky illegal-opcode flag for board-level debug.

Parameters:
- WIDTH, 8, operand/result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts a request this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; B[2:0] is the shift/rotate amount.
- sel  input  4  opcode.
- carry_in  input  1  carry/borrow in, used only by ADD/SUB.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- results  output  WIDTH  result.
- carry_out  output  1  carry/borrow/shift-out.
- illegal  output  1  current output came from an unused opcode.
- op_count  output  CNT_W  number of results delivered.
- illegal_seen  output  1  sticky; set by any delivered illegal result.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, results=0, carry_out=0, illegal=0, op_count=0, illegal_seen=0. in_ready is 1 one cycle after release.
- Request accepted on in_valid&&in_ready. Result delivered on out_valid&&out_ready.
- Stage 1 registers A, B, sel and carry_in. Stage 2 registers the computed result, carry and illegal bit; stage 2 drives the outputs.
- Latency: accepted at edge N, out_valid at edge N+2 (visible after edge N+1).
- Throughput: 1 op per cycle while out_ready=1.
- Backpressure:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = !s1_valid || s2 advances (combinational from out_ready; no skid buffer).
  - Outputs stay stable while out_valid && !out_ready.
- Opcodes (sel):
  - 0 ADD: {carry_out,results} = A + B + carry_in.
  - 1 SUB: results = A - B - carry_in; carry_out = borrow (1 when A < B + carry_in).
  - 2 SHL by n=B[2:0]: zero fill; carry_out = last bit shifted out (A[WIDTH-n]), 0 when n=0.
  - 3 SHR by n: zero fill; carry_out = A[n-1], 0 when n=0.
  - 4 ROL by n, 5 ROR by n: carry_out=0.
  - 6 AND, 7 OR, 8 NOT (~A, B ignored), 9 NAND, 10 XOR, 11 XNOR, 12 NOR: carry_out=0.
  - 13–15 illegal: results=0, carry_out=0, illegal=1.
- op_count increments on each delivered result and wraps from 2^CNT_W-1 to 0.
- illegal_seen sets on delivery of an illegal result; it clears only on reset.
- Accepting a request and delivering a result in the same cycle is allowed; the pipeline stays full.
- Reset asserted mid-operation discards all in-flight ops. No result is produced for them.
- Inputs are sampled only on acceptance. Changes while in_ready=0 have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD…OP_NOR (0–12) and OP_ILLEGAL_MIN=13;
  - the WIDTH default;
  - a packed struct {results, carry_out, illegal} as the stage-2 payload.
- One combinational sub-module, alu_core: pure function of (A, B, sel, carry_in) to the payload. alu_pipe holds only the handshake, pipeline registers, counter and sticky flag.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, op_count=0, in_ready=1 after release. Assert rst_n=0 with 2 ops in flight → no output, counters cleared.
- ADD/SUB: A=8'hFF, B=8'h01, cin=0, ADD → results=8'h00, carry_out=1, out_valid exactly 2 cycles after accept. A=8'h00, B=8'h01, cin=1, SUB → results=8'hFE, carry_out=1.
- Shift/rotate: A=8'h81, B=3, SHL → 8'h08, carry_out=0. SHR → 8'h10, carry_out=0. ROL → 8'h0C. ROR → 8'h30. B=0 SHL → 8'h81, carry_out=0.
- Logical: A=8'hF0, B=8'h3C → AND 8'h30, OR 8'hFC, NOT 8'h0F, NAND 8'hCF, XOR 8'hCC, XNOR 8'h33, NOR 8'h03.
- Backpressure: stream 6 ops with out_ready low for 4 cycles → in_ready=0 once 2 ops are held, no loss or duplication, outputs stable, in-order delivery, op_count=6.
- Illegal/wrap: sel=4'hE → results=0, illegal=1, illegal_seen stays 1. Preload by issuing 65536 ops → op_count wraps to 0.
